// File: rtl/pixel_pkg.sv
// Shared pixel types, legal kernel sizes and window tap addressing for the
// sliding window buffer.
`timescale 1ns/1ps

package pixel_pkg;

    // Default pixel width of the video pipeline.
    localparam int unsigned PIXEL_WIDTH = 12;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Window edge sizes the buffer supports.
    localparam int unsigned KERNEL_SMALL = 3;
    localparam int unsigned KERNEL_LARGE = 5;

    // Width of the 1-based tap offset used when building flattened windows.
    localparam int unsigned TAP_STRIDE_ONE = 1;

    function automatic bit kernel_is_legal(input int unsigned kernel);
        return (kernel == KERNEL_SMALL) || (kernel == KERNEL_LARGE);
    endfunction

    // Lowest bit of tap (r,c) inside a flattened kernel*kernel window.
    function automatic int unsigned tap_lsb(
        input int unsigned r,
        input int unsigned c,
        input int unsigned kernel,
        input int unsigned width
    );
        return (r * kernel + c) * width * TAP_STRIDE_ONE;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated pixel delay line: dout_c presents the pixel written DEPTH
// enables ago, and the slot is overwritten with din on the same enable.
`timescale 1ns/1ps

module line_delay #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      ptr_q;

    // Read-before-write: the slot about to be reused holds the oldest pixel.
    assign dout_c = mem_q[ptr_q];

    // Circular slot pointer, advances once per enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Storage; contents after reset are masked by the window's row counter.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sliding_window_buffer.sv
// KERNEL x KERNEL sliding window over a raster pixel stream, built from a
// chain of KERNEL-1 line delays and a register window shifted per accepted
// pixel. Ready/valid on both sides with a one-cycle accept-to-window latency.
// Optional macro BORDER_ZERO_EN: emit a window for every pixel with
// out-of-frame taps forced to zero; otherwise only fully populated windows.
`timescale 1ns/1ps

module sliding_window_buffer
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned KERNEL     = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                s_pixel,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic                                 s_sof,
    input  logic                                 s_eol,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  m_window,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_sof,
    output logic                                 m_eol,
    output logic                                 line_err
);

    localparam int unsigned COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned ROW_W = $clog2(KERNEL);

    logic                  accept_c;
    logic [COL_W-1:0]      col_q;
    logic [COL_W-1:0]      eff_col_c;
    logic [COL_W-1:0]      col_next_c;
    logic [ROW_W-1:0]      row_q;
    logic [ROW_W-1:0]      eff_row_c;
    logic [ROW_W-1:0]      row_next_c;
    logic                  last_col_c;
    logic                  line_end_c;
    logic                  len_bad_c;
    logic                  emit_c;
    logic                  eff_sof_c;
    logic [KERNEL-1:0]     row_ok_c;
    logic [KERNEL-1:0]     col_ok_c;

    logic [DATA_WIDTH-1:0] win_q      [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0] tap_next_c [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0] col0_c     [KERNEL];
    logic [DATA_WIDTH-1:0] ld_out_c   [KERNEL-1];

`ifndef BORDER_ZERO_EN
    logic                  sof_pending_q;
`endif

    // Upstream may push whenever the output slot is empty or draining.
    assign s_ready  = !m_valid || m_ready;
    assign accept_c = s_valid && s_ready;

    // Position of the incoming pixel, line-end/length decode and emit decision.
    always_comb begin
        eff_col_c  = s_sof ? '0 : col_q;
        eff_row_c  = s_sof ? '0 : row_q;
        last_col_c = (eff_col_c == COL_W'(LINE_WIDTH - 1));
        line_end_c = s_eol || last_col_c;
        len_bad_c  = s_eol ^ last_col_c;
        col_next_c = line_end_c ? '0 : eff_col_c + COL_W'(1);
        row_next_c = eff_row_c;
        if (line_end_c && (eff_row_c != ROW_W'(KERNEL - 1))) begin
            row_next_c = eff_row_c + ROW_W'(1);
        end
`ifdef BORDER_ZERO_EN
        emit_c    = 1'b1;
        eff_sof_c = s_sof;
`else
        emit_c    = (eff_row_c == ROW_W'(KERNEL - 1)) &&
                    (eff_col_c >= COL_W'(KERNEL - 1));
        eff_sof_c = s_sof || sof_pending_q;
`endif
    end

    // Per-row / per-column validity of taps relative to the incoming pixel.
    for (genvar i = 0; i < KERNEL; i++) begin : g_ok
        if (i == 0) begin : g_first
            assign row_ok_c[i] = 1'b1;
            assign col_ok_c[i] = 1'b1;
        end else begin : g_rest
            assign row_ok_c[i] = (eff_row_c >= ROW_W'(i));
            assign col_ok_c[i] = (eff_col_c >= COL_W'(i));
        end
    end

    // Line delay chain: stage k outputs the pixel (k+1) lines above.
    for (genvar k = 0; k < KERNEL - 1; k++) begin : g_line
        logic [DATA_WIDTH-1:0] din_c;
        if (k == 0) begin : g_head
            assign din_c = s_pixel;
        end else begin : g_tail
            assign din_c = ld_out_c[k-1];
        end
        line_delay #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINE_WIDTH)
        ) u_line_delay (
            .clk    (clk),
            .rst    (rst),
            .en     (accept_c),
            .din    (din_c),
            .dout_c (ld_out_c[k])
        );
    end

    // Next window: column 0 from the input and delays, others shifted, with
    // taps outside the current frame forced to zero.
    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        if (r == 0) begin : g_new
            assign col0_c[r] = s_pixel;
        end else begin : g_old
            assign col0_c[r] = ld_out_c[r-1];
        end
        for (genvar c = 0; c < KERNEL; c++) begin : g_col
            localparam int unsigned LSB = tap_lsb(r, c, KERNEL, DATA_WIDTH);
            logic [DATA_WIDTH-1:0] src_c;
            if (c == 0) begin : g_load
                assign src_c = col0_c[r];
            end else begin : g_shift
                assign src_c = win_q[r][c-1];
            end
            assign tap_next_c[r][c]             = (row_ok_c[r] && col_ok_c[c]) ? src_c : '0;
            assign m_window[LSB +: DATA_WIDTH]  = win_q[r][c];
        end
    end

    // Window registers update only on accept, so a stalled window holds.
    always_ff @(posedge clk) begin
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                if (rst) begin
                    win_q[r][c] <= '0;
                end else if (accept_c) begin
                    win_q[r][c] <= tap_next_c[r][c];
                end
            end
        end
    end

    // Raster counters, sticky length error and output handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            line_err <= 1'b0;
            m_valid  <= 1'b0;
            m_sof    <= 1'b0;
            m_eol    <= 1'b0;
        end else if (accept_c) begin
            col_q   <= col_next_c;
            row_q   <= row_next_c;
            m_valid <= emit_c;
            m_sof   <= emit_c && eff_sof_c;
            m_eol   <= emit_c && s_eol;
            if (len_bad_c) begin
                line_err <= 1'b1;
            end
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end
    end

`ifndef BORDER_ZERO_EN
    // Remembers a frame start until its first complete window goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sof_pending_q <= 1'b0;
        end else if (accept_c) begin
            sof_pending_q <= eff_sof_c && !emit_c;
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Bench for sliding_window_buffer (LINE_WIDTH=4, KERNEL=3, DATA_WIDTH=12),
// checked against a frame-image reference model.
`timescale 1ns/1ps

module tb_sliding_window_buffer;

    localparam int unsigned DW = 12;
    localparam int unsigned LW = 4;
    localparam int unsigned K  = 3;
    localparam int unsigned WW = K * K * DW;
    localparam int          MAXROW = 16;

    typedef struct packed {
        logic [DW-1:0] pix;
        logic          sof;
        logic          eol;
    } px_t;

    typedef struct packed {
        logic [WW-1:0] win;
        logic          sof;
        logic          eol;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_pixel = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_sof = 1'b0;
    logic          s_eol = 1'b0;
    logic [WW-1:0] m_window;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_sof;
    logic          m_eol;
    logic          line_err;

    always #5 clk = ~clk;

    sliding_window_buffer #(
        .DATA_WIDTH (DW),
        .LINE_WIDTH (LW),
        .KERNEL     (K)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_pixel  (s_pixel),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_sof    (s_sof),
        .s_eol    (s_eol),
        .m_window (m_window),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sof    (m_sof),
        .m_eol    (m_eol),
        .line_err (line_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the current frame as a 2-D image plus raster position.
    logic [DW-1:0] img [MAXROW][LW];
    int            mrow, mcol;
    bit            exp_valid, exp_sof, exp_eol, exp_err;
    logic [WW-1:0] exp_win;
    bit            chk_win = 1'b1;
`ifndef BORDER_ZERO_EN
    bit            pend;
`endif

    px_t  stim_q [$];
    obs_t obs_q  [$];
    obs_t ref_q  [$];

    function automatic logic [WW-1:0] tap_set(input logic [WW-1:0] w, input int r, input int c,
                                              input logic [DW-1:0] v);
        logic [WW-1:0] t;
        t = w;
        t[(r*K+c)*DW +: DW] = v;
        return t;
    endfunction

    function automatic logic [DW-1:0] tap_of(input logic [WW-1:0] w, input int r, input int c);
        return w[(r*K+c)*DW +: DW];
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_sof   = 1'b0;
        exp_eol   = 1'b0;
        exp_err   = 1'b0;
        exp_win   = '0;
        mrow      = 0;
        mcol      = 0;
`ifndef BORDER_ZERO_EN
        pend      = 1'b0;
`endif
    endtask

    task automatic model_accept(input px_t p);
        logic [WW-1:0] w;
        bit            emit;
        if (p.sof) begin
            mrow = 0;
            mcol = 0;
`ifndef BORDER_ZERO_EN
            pend = 1'b1;
`endif
        end
        if (mrow < MAXROW) img[mrow][mcol] = p.pix;
        w = '0;
        for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) begin
                if (mrow - r >= 0 && mcol - c >= 0 && mrow - r < MAXROW)
                    w = tap_set(w, r, c, img[mrow-r][mcol-c]);
            end
        end
`ifdef BORDER_ZERO_EN
        emit    = 1'b1;
        exp_sof = p.sof;
`else
        emit = (mrow >= int'(K) - 1) && (mcol >= int'(K) - 1);
        if (emit) begin
            exp_sof = pend;
            pend    = 1'b0;
        end
`endif
        exp_valid = emit;
        if (emit) begin
            exp_win = w;
            exp_eol = p.eol;
        end
        if (p.eol != (mcol == int'(LW) - 1)) exp_err = 1'b1;
        if (p.eol || mcol == int'(LW) - 1) begin
            mcol = 0;
            mrow++;
        end else begin
            mcol++;
        end
    endtask

    // One clock: check outputs, drive inputs, check ready, advance the model.
    task automatic step(input px_t p, input bit v, input bit rdy, output bit acc, output bit sr);
        @(negedge clk);
        check_eq("m_valid", 128'(m_valid), 128'(exp_valid));
        if (exp_valid) begin
            if (chk_win) check_eq("m_window", 128'(m_window), 128'(exp_win));
            check_eq("m_sof", 128'(m_sof), 128'(exp_sof));
            check_eq("m_eol", 128'(m_eol), 128'(exp_eol));
        end
        check_eq("line_err", 128'(line_err), 128'(exp_err));
        s_valid = v;
        s_pixel = p.pix;
        s_sof   = p.sof;
        s_eol   = p.eol;
        m_ready = rdy;
        #1;
        sr = s_ready;
        check_eq("s_ready", 128'(s_ready), 128'(!exp_valid || rdy));
        if (m_valid && rdy) obs_q.push_back('{win: m_window, sof: m_sof, eol: m_eol});
        acc = v && (!exp_valid || rdy);
        if (acc) model_accept(p);
        else if (rdy) exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        s_pixel = '0;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("rst_m_valid", 128'(m_valid), 128'(0));
        check_eq("rst_m_sof", 128'(m_sof), 128'(0));
        check_eq("rst_m_eol", 128'(m_eol), 128'(0));
        check_eq("rst_line_err", 128'(line_err), 128'(0));
        check_eq("rst_m_window", 128'(m_window), 128'(0));
        #1;
        check_eq("rst_s_ready", 128'(s_ready), 128'(1));
    endtask

    task automatic add_frame(input int rows, input int cols_last, input bit eol_on, input bit rnd,
                             input int base);
        int n;
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < int'(LW); c++) begin
                px_t p;
                if (r == 0 && c >= cols_last) break;
                p.pix = rnd ? DW'($urandom) : DW'(base + n);
                p.sof = (n == 0);
                p.eol = eol_on && ((r == 0) ? (c == cols_last - 1) : (c == int'(LW) - 1));
                stim_q.push_back(p);
                n++;
            end
        end
    endtask

    task automatic run_stream(input int vpct, input int rpct, input int stall_at, input int stall_len,
                              output int stall_lo);
        int i, cyc;
        bit acc, sr, v, rdy, in_stall;
        px_t idle;
        idle = '0;
        i = 0;
        cyc = 0;
        stall_lo = 0;
        while (i < stim_q.size() && cyc < 4000) begin
            in_stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            v   = int'($urandom_range(99)) < vpct;
            rdy = in_stall ? 1'b0 : (int'($urandom_range(99)) < rpct);
            step(stim_q[i], v, rdy, acc, sr);
            if (in_stall && !sr) stall_lo++;
            if (acc) i++;
            cyc++;
        end
        check_eq("stream_done", 128'(i), 128'(stim_q.size()));
        repeat (4) step(idle, 1'b0, 1'b1, acc, sr);
    endtask

    initial begin
        int            lo;
        logic [WW-1:0] w;
        model_reset();
        do_reset();

        // Pixels 1..16, one frame of 4 full lines, free-flowing.
        stim_q.delete();
        add_frame(4, LW, 1'b1, 1'b0, 1);
        obs_q.delete();
        run_stream(100, 100, -1, 0, lo);
`ifdef BORDER_ZERO_EN
        check_eq("win_count", 128'(obs_q.size()), 128'(16));
        w = tap_set('0, 0, 0, DW'(1));
        check_eq("px1_window", 128'(obs_q[0].win), 128'(w));
        check_eq("px1_sof", 128'(obs_q[0].sof), 128'(1));
        check_eq("px6_tap11", 128'(tap_of(obs_q[5].win, 1, 1)), 128'(1));
        check_eq("px6_tap02", 128'(tap_of(obs_q[5].win, 0, 2)), 128'(0));
`else
        check_eq("win_count", 128'(obs_q.size()), 128'(4));
        w = '0;
        w = tap_set(w, 0, 0, DW'(11)); w = tap_set(w, 0, 1, DW'(10)); w = tap_set(w, 0, 2, DW'(9));
        w = tap_set(w, 1, 0, DW'(7));  w = tap_set(w, 1, 1, DW'(6));  w = tap_set(w, 1, 2, DW'(5));
        w = tap_set(w, 2, 0, DW'(3));  w = tap_set(w, 2, 1, DW'(2));  w = tap_set(w, 2, 2, DW'(1));
        check_eq("first_window", 128'(obs_q[0].win), 128'(w));
        check_eq("first_sof", 128'(obs_q[0].sof), 128'(1));
        check_eq("second_sof", 128'(obs_q[1].sof), 128'(0));
        check_eq("second_eol", 128'(obs_q[1].eol), 128'(1));
`endif
        ref_q = obs_q;

        // Same frame with a 5-cycle downstream stall mid-frame.
        do_reset();
        obs_q.delete();
        run_stream(100, 100, 11, 5, lo);
        check_eq("stall_s_ready_low", 128'(lo), 128'(5));
        check_eq("stall_count", 128'(obs_q.size()), 128'(ref_q.size()));
        for (int i = 0; i < ref_q.size(); i++) check_eq("stall_seq", 128'(obs_q[i]), 128'(ref_q[i]));

        // Nine pixels of a different frame, reset, then the reference frame.
        do_reset();
        stim_q.delete();
        add_frame(4, LW, 1'b1, 1'b0, 101);
        stim_q = stim_q[0:8];
        run_stream(100, 100, -1, 0, lo);
        do_reset();
        stim_q.delete();
        add_frame(4, LW, 1'b1, 1'b0, 1);
        obs_q.delete();
        run_stream(100, 100, -1, 0, lo);
        check_eq("post_rst_count", 128'(obs_q.size()), 128'(ref_q.size()));
        for (int i = 0; i < ref_q.size(); i++) check_eq("post_rst_seq", 128'(obs_q[i]), 128'(ref_q[i]));

        // Short first line (eol on third pixel) then two full lines.
        do_reset();
        chk_win = 1'b0;
        stim_q.delete();
        add_frame(3, 3, 1'b1, 1'b0, 1);
        obs_q.delete();
        run_stream(100, 100, -1, 0, lo);
        check_eq("short_line_err", 128'(line_err), 128'(1));
`ifdef BORDER_ZERO_EN
        check_eq("short_line_wins", 128'(obs_q.size()), 128'(11));
`else
        check_eq("short_line_wins", 128'(obs_q.size()), 128'(2));
`endif
        chk_win = 1'b1;

        // Full-length line without eol.
        do_reset();
        stim_q.delete();
        add_frame(1, LW, 1'b0, 1'b0, 1);
        run_stream(100, 100, -1, 0, lo);
        check_eq("missing_eol_err", 128'(line_err), 128'(1));

        // Random pixels with random valid/ready over several frames.
        do_reset();
        stim_q.delete();
        for (int f = 0; f < 3; f++) add_frame(int'($urandom_range(6, 3)), LW, 1'b1, 1'b1, 0);
        run_stream(75, 70, -1, 0, lo);
        check_eq("rand_no_err", 128'(line_err), 128'(0));

        // Random partial frame, reset mid-frame, then a random frame.
        stim_q.delete();
        add_frame(3, LW, 1'b1, 1'b1, 0);
        stim_q = stim_q[0:6];
        run_stream(80, 60, -1, 0, lo);
        do_reset();
        stim_q.delete();
        add_frame(5, LW, 1'b1, 1'b1, 0);
        run_stream(70, 80, -1, 0, lo);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sliding_window_buffer.md
SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 12, pixel width in bits.
REQ-002 SHALL have parameter LINE_WIDTH, 640, pixels per line and depth of each line delay.
REQ-003 SHALL have parameter KERNEL, 3, window edge size; legal values 3 and 5.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port s_pixel, input, DATA_WIDTH, incoming pixel.
REQ-007 SHALL have port s_valid, input, 1, s_pixel/s_sof/s_eol valid.
REQ-008 SHALL have port s_ready, output, 1, block accepts a pixel this cycle.
REQ-009 SHALL have port s_sof, input, 1, the pixel is the first of a frame.
REQ-010 SHALL have port s_eol, input, 1, the pixel is the last of a line.
REQ-011 SHALL have port m_window, output, KERNEL*KERNEL*DATA_WIDTH, flattened window; tap (r,c) at bits (r*KERNEL+c)*DATA_WIDTH upward.
REQ-012 SHALL have port m_valid, output, 1, m_window valid.
REQ-013 SHALL have port m_ready, input, 1, downstream accepts the window.
REQ-014 SHALL have port m_sof, output, 1, first window of a frame.
REQ-015 SHALL have port m_eol, output, 1, the window's newest pixel had s_eol.
REQ-016 SHALL have port line_err, output, 1, sticky line-length error flag.

Function
REQ-017 Accept occurs when s_valid && s_ready; s_ready SHALL equal !m_valid || m_ready.
REQ-018 Tap (r,c) SHALL hold the pixel at (row-r, col-c) relative to the newest accepted pixel at (row, col); r=0 is the newest row, c=0 the newest column.
REQ-019 Each accept SHALL shift all window columns by one and load column 0 from s_pixel and the KERNEL-1 line-delay outputs, in one operation.
REQ-020 Latency SHALL be one cycle: the window containing an accepted pixel is presented with m_valid on the next cycle.
REQ-021 m_valid, m_window, m_sof and m_eol SHALL hold stable while m_valid && !m_ready.
REQ-022 The column counter SHALL clear after a pixel with s_eol or at col = LINE_WIDTH-1, and otherwise increment.
REQ-023 The row counter SHALL increment at every line end and saturate at KERNEL-1.
REQ-024 An accepted pixel with s_sof SHALL take position row 0, col 0 regardless of counter state; no tap from before it is ever exposed as valid data.
REQ-025 line_err SHALL set when s_eol arrives with col != LINE_WIDTH-1, or when col = LINE_WIDTH-1 without s_eol; it SHALL clear only on rst.
REQ-026 Line delays SHALL advance only on accept; stalls SHALL neither drop nor duplicate pixels.

Reset
REQ-027 On rst: m_valid=0, m_sof=0, m_eol=0, line_err=0, m_window=0, counters=0; line-delay contents are undefined and are masked by the counters.
REQ-028 Reset mid-frame SHALL discard any partial window; the first pixel accepted after reset SHALL be treated as row 0, col 0.
REQ-029 s_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 Macro BORDER_ZERO_EN: when defined, every accepted pixel SHALL produce one window; taps with row-r < 0 or col-c < 0 SHALL read 0; m_sof SHALL accompany the window of the s_sof pixel.
REQ-031 When BORDER_ZERO_EN is undefined, a window SHALL be produced only when row >= KERNEL-1 and col >= KERNEL-1; other accepts SHALL update state without asserting m_valid; m_sof SHALL mark the first such window of a frame.

Structure
REQ-032 Package pixel_pkg SHALL hold the pixel_t typedef (DATA_WIDTH bits), the legal KERNEL values, and the tap-offset helper constant.
REQ-033 One sub-module, line_delay, SHALL implement a LINE_WIDTH-deep enable-gated pixel delay; KERNEL-1 instances SHALL be chained.

Verification (LINE_WIDTH=4, KERNEL=3, DATA_WIDTH=12)
REQ-034 Feed pixels 1..16 with s_sof on pixel 1 and s_eol every fourth pixel, m_ready=1, macro undefined -> exactly 4 windows; the first has m_sof and taps (0,0..2)=11,10,9, (1,0..2)=7,6,5, (2,0..2)=3,2,1.
REQ-035 Same stimulus with BORDER_ZERO_EN -> 16 windows; the window for pixel 1 has tap(0,0)=1 and all other taps 0; the window for pixel 6 has tap(1,1)=1 and tap(0,2)=0.
REQ-036 Hold m_ready=0 for 5 cycles mid-frame -> s_ready=0 and window stable throughout; resume -> output sequence identical to REQ-034.
REQ-037 Assert s_eol on the third pixel of a line -> line_err=1 and stays 1; the next pixel takes col 0.
REQ-038 Assert rst after pixel 9, then feed 16 pixels with s_sof -> no window contains pre-reset data; results match REQ-034.
